// File: rtl/pre_ddr_unpack_buf_pkg.sv
// Shared constants and read-FSM state type for the DDR3 ingress unpack buffer.
// Widths here are defaults; the top and RAM take them as parameters.
package pre_ddr_unpack_buf_pkg;

    localparam int DEF_DATA_W    = 512;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_PKT_WORDS = 5;
    localparam int WORD_BYTES    = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT
    } rd_state_t;

endpackage

// File: rtl/sdp_ram_512x32.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data appears one cycle after rd_addr is presented.
module sdp_ram_512x32
    import pre_ddr_unpack_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pre_ddr_unpack_buf.sv
// Buffers 512-bit DDR3 read words and replays complete packets
// as a valid/ready byte stream, MSB byte of each word first.
module pre_ddr_unpack_buf
    import pre_ddr_unpack_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PKT_WORDS = DEF_PKT_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              buf_full,
    output logic              pkt_ready,
    output logic [7:0]        data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              pkt_done,
    output logic              ovf_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int WC_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(PKT_WORDS - 1);
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   PKT       = (ADDR_W + 1)'(PKT_WORDS);

    rd_state_t         state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   used;
    logic [3:0]        pkt_cnt;
    logic [WC_W-1:0]   wr_word_cnt;
    logic [WC_W-1:0]   rd_word_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] ram_dout;

    logic wr_ok;
    logic pkt_in;
    logic pkt_out;
    logic load;
    logic accept;
    logic last_byte;

    assign wr_ok     = wr_en && (used != FULL);
    assign pkt_in    = wr_ok && (wr_word_cnt == LAST_WORD);
    assign pkt_out   = (state == IDLE) && (pkt_cnt != 4'd0);
    assign load      = (state == LOAD);
    assign accept    = (state == SHIFT) && data_ready;
    assign last_byte = accept && (byte_cnt == LAST_BYTE);

    assign pkt_ready  = (pkt_cnt != 4'd0);
    assign data_valid = (state == SHIFT);
    assign data_out   = shift_reg[DATA_W-1 -: 8];
    assign pkt_done   = last_byte && (rd_word_cnt == LAST_WORD);

    sdp_ram_512x32 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (ram_dout)
    );

    // A write into a full RAM is dropped and latched as an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_word_cnt <= '0;
            ovf_err     <= 1'b0;
        end else if (wr_ok) begin
            wr_addr     <= wr_addr + 1'b1;
            wr_word_cnt <= (wr_word_cnt == LAST_WORD) ? '0 : wr_word_cnt + 1'b1;
        end else if (wr_en) begin
            ovf_err     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used     <= '0;
            pkt_cnt  <= '0;
            buf_full <= 1'b0;
        end else begin
            unique case ({wr_ok, load})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
            unique case ({pkt_in, pkt_out})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
            buf_full <= (FULL - used) < PKT;
        end
    end

    // Reader: RAM has one cycle of latency, so FETCH presents the
    // address and LOAD captures the word into the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_addr     <= '0;
            rd_word_cnt <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_word_cnt <= '0;
                    if (pkt_cnt != 4'd0) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= ram_dout;
                    rd_addr   <= rd_addr + 1'b1;
                    byte_cnt  <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (accept) begin
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt + 1'b1;
                    end
                    if (last_byte) begin
                        if (rd_word_cnt == LAST_WORD) begin
                            state <= IDLE;
                        end else begin
                            rd_word_cnt <= rd_word_cnt + 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_ddr_unpack_buf.sv
// Randomised bench for pre_ddr_unpack_buf: a packet-level byte-queue
// model predicts the stream; flags are checked at known points.
module tb_pre_ddr_unpack_buf;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [511:0] wr_data = '0;
    logic         data_ready;
    logic         buf_full;
    logic         pkt_ready;
    logic [7:0]   data_out;
    logic         data_valid;
    logic         pkt_done;
    logic         ovf_err;

    int vectors = 0;
    int errors = 0;
    int pos = 0;
    int accepted = 0;
    int budget = 0;
    int rdy_mode = 0;
    int dones = 0;

    logic [7:0]   exp_q[$];
    logic [511:0] word_q[$];
    logic [511:0] stage_q[$];

    pre_ddr_unpack_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .buf_full   (buf_full),
        .pkt_ready  (pkt_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .pkt_done   (pkt_done),
        .ovf_err    (ovf_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Only whole packets of five words ever become expected bytes.
    task automatic model_push(input logic [511:0] w);
        logic [511:0] x;
        word_q.push_back(w);
        if (word_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                x = word_q.pop_front();
                for (int b = 0; b < 64; b++) begin
                    exp_q.push_back(x[511 - 8*b -: 8]);
                end
            end
        end
    endtask

    function automatic logic [511:0] pattern_word(input int k);
        logic [511:0] w;
        for (int b = 0; b < 64; b++) begin
            w[511 - 8*b -: 8] = 8'((64 * k + b) % 256);
        end
        return w;
    endfunction

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) begin
            w[32*i +: 32] = $urandom;
        end
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        word_q.delete();
        pos = 0;
    endtask

    // Back-to-back writes of everything staged; index drop_idx is
    // expected to be refused by a full buffer.
    task automatic burst(input int drop_idx);
        for (int i = 0; i < stage_q.size(); i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_data = stage_q[i];
            if (i != drop_idx) model_push(stage_q[i]);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        stage_q.delete();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_valid", 32'(data_valid), 32'd0);
    endtask

    task automatic wait_budget(input int maxc);
        int n = 0;
        while (budget > 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        check("budget_left", 32'(budget), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_dout"},  32'(data_out),   32'd0);
        check({tag, "_done"},  32'(pkt_done),   32'd0);
        check({tag, "_prdy"},  32'(pkt_ready),  32'd0);
        check({tag, "_full"},  32'(buf_full),   32'd0);
        check({tag, "_ovf"},   32'(ovf_err),    32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       data_ready = 1'b1;
                2:       data_ready = 1'($urandom_range(0, 1));
                3:       data_ready = (budget > 0);
                default: data_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    check("data_out", 32'(data_out), 32'(exp_q[0]));
                    if (data_ready) begin
                        check("pkt_done", 32'(pkt_done), 32'(pos == 319));
                        void'(exp_q.pop_front());
                        pos = (pos == 319) ? 0 : pos + 1;
                        accepted++;
                        if (budget > 0) budget--;
                    end else begin
                        check("done_stall", 32'(pkt_done), 32'd0);
                    end
                end
            end else begin
                check("done_idle", 32'(pkt_done), 32'd0);
            end
            if (pkt_done) dones++;
        end
    end

    initial begin
        int d0;
        int target;
        int n;

        do_reset();

        // Counting pattern, always ready.
        for (int k = 0; k < 5; k++) stage_q.push_back(pattern_word(k));
        rdy_mode = 1;
        d0 = dones;
        burst(-1);
        drain(2000);
        check("single_prdy", 32'(pkt_ready), 32'd0);
        check("single_dones", 32'(dones - d0), 32'd1);

        // Same packet under random backpressure.
        for (int k = 0; k < 5; k++) stage_q.push_back(pattern_word(k));
        rdy_mode = 2;
        d0 = dones;
        burst(-1);
        drain(5000);
        check("bp_dones", 32'(dones - d0), 32'd1);

        // Three random-data packets under backpressure.
        for (int k = 0; k < 15; k++) stage_q.push_back(rand_word());
        d0 = dones;
        burst(-1);
        drain(10000);
        check("rand_dones", 32'(dones - d0), 32'd3);

        // Partial packet stays invisible until completed.
        do_reset();
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) stage_q.push_back(rand_word());
        burst(-1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check("part_prdy", 32'(pkt_ready), 32'd0);
            check("part_valid", 32'(data_valid), 32'd0);
        end
        stage_q.push_back(rand_word());
        burst(-1);
        check("lat_prdy", 32'(pkt_ready), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("lat_early", 32'(data_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("lat_first", 32'(data_valid), 32'd1);
        drain(2000);

        // Full-flag thresholds around free == PKT_WORDS.
        do_reset();
        rdy_mode = 3;
        budget = 0;
        for (int k = 0; k < 25; k++) stage_q.push_back(rand_word());
        burst(-1);
        repeat (3) @(posedge clk);
        #1;
        check("full_24", 32'(buf_full), 32'd0);
        for (int k = 0; k < 5; k++) stage_q.push_back(rand_word());
        burst(-1);
        repeat (3) @(posedge clk);
        #1;
        check("full_29", 32'(buf_full), 32'd1);
        budget = 64;
        wait_budget(500);
        repeat (6) @(posedge clk);
        #1;
        check("full_28", 32'(buf_full), 32'd1);
        budget = 128;
        wait_budget(1000);
        repeat (6) @(posedge clk);
        #1;
        check("full_26", 32'(buf_full), 32'd0);
        rdy_mode = 1;
        drain(5000);

        // Overflow: the first word is loaded before the RAM fills, so
        // 33 writes fit and the 34th is refused.
        do_reset();
        rdy_mode = 0;
        for (int k = 0; k < 33; k++) stage_q.push_back(rand_word());
        burst(-1);
        check("ovf_before", 32'(ovf_err), 32'd0);
        check("ovf_full", 32'(buf_full), 32'd1);
        stage_q.push_back(rand_word());
        burst(0);
        check("ovf_set", 32'(ovf_err), 32'd1);
        rdy_mode = 1;
        drain(5000);
        check("ovf_partial", 32'(word_q.size()), 32'd3);
        for (int k = 0; k < 2; k++) stage_q.push_back(rand_word());
        burst(-1);
        drain(2000);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) stage_q.push_back(rand_word());
        target = accepted + 100;
        burst(-1);
        n = 0;
        while (accepted < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("mid_reach", 32'(accepted >= target), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid");
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_quiet", 32'(data_valid), 32'd0);
        d0 = dones;
        for (int k = 0; k < 5; k++) stage_q.push_back(rand_word());
        burst(-1);
        drain(2000);
        check("mid_dones", 32'(dones - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
